// File: rtl/sb_ring_buffer.sv
// -----------------------------------------------------------------------------
// sb_ring_buffer - parametrised issue/commit scoreboard ring buffer.
//
// Allocates transaction IDs in program order at the tail. It collects
// out-of-order writebacks from NR_WB_PORTS functional-unit ports and retires
// entries in order from the head. It also offers busy/forwarding lookup for
// two source registers.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   flush_i              discard every entry (highest priority)
//   issue_*              issue handshake, rd, immediate; issue_trans_id_o = tail
//   wb_*                 per-port writeback strobe, ID, result, exception
//   commit_*             head entry view and acknowledge
//   rsN_addr_i           lookup address; rsN_busy_o / rsN_fwd_valid_o / rsN_fwd_o
//   full_o               all NR_ENTRIES slots allocated
//
// Optional feature macro: SB_WB_BYPASS_EN
//   When defined, the lookup also sees same-cycle writebacks to the youngest
//   matching entry. Commit stays purely registered.
// -----------------------------------------------------------------------------
module sb_ring_buffer #(
    parameter int NR_ENTRIES  = 8,
    parameter int NR_WB_PORTS = 4,
    parameter int DATA_W      = 64,
    localparam int TRANS_ID_W = $clog2(NR_ENTRIES)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            issue_valid_i,
    output logic                            issue_ready_o,
    input  logic [4:0]                      issue_rd_i,
    input  logic [DATA_W-1:0]               issue_data_i,
    output logic [TRANS_ID_W-1:0]           issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]          wb_valid_i,
    input  logic [NR_WB_PORTS*TRANS_ID_W-1:0] wb_trans_id_i,
    input  logic [NR_WB_PORTS*DATA_W-1:0]   wb_result_i,
    input  logic [NR_WB_PORTS-1:0]          wb_ex_i,
    output logic                            commit_valid_o,
    input  logic                            commit_ack_i,
    output logic [TRANS_ID_W-1:0]           commit_trans_id_o,
    output logic [4:0]                      commit_rd_o,
    output logic [DATA_W-1:0]               commit_result_o,
    output logic                            commit_ex_o,
    input  logic [4:0]                      rs1_addr_i,
    input  logic [4:0]                      rs2_addr_i,
    output logic                            rs1_busy_o,
    output logic                            rs2_busy_o,
    output logic                            rs1_fwd_valid_o,
    output logic                            rs2_fwd_valid_o,
    output logic [DATA_W-1:0]               rs1_fwd_o,
    output logic [DATA_W-1:0]               rs2_fwd_o,
    output logic                            full_o
);

    localparam logic [TRANS_ID_W:0]   FULL_CNT = (TRANS_ID_W+1)'(NR_ENTRIES);
    localparam logic [TRANS_ID_W:0]   CNT_ONE  = (TRANS_ID_W+1)'(1);
    localparam logic [TRANS_ID_W-1:0] PTR_ONE  = TRANS_ID_W'(1);

    logic [NR_ENTRIES-1:0]  alloc_q, alloc_d, done_q, done_d, ex_q, ex_d;
    logic [4:0]             rd_q     [NR_ENTRIES];
    logic [4:0]             rd_d     [NR_ENTRIES];
    logic [DATA_W-1:0]      result_q [NR_ENTRIES];
    logic [DATA_W-1:0]      result_d [NR_ENTRIES];
    logic [TRANS_ID_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TRANS_ID_W:0]    cnt_q, cnt_d;

    logic                   issue_fire_s, commit_fire_s;
    logic [NR_ENTRIES-1:0]  wb_hit_s, wb_ex_s;
    logic [DATA_W-1:0]      wb_res_s [NR_ENTRIES];

    logic                   lk_busy_s  [2];
    logic                   lk_fwdv_s  [2];
    logic [DATA_W-1:0]      lk_fwd_s   [2];

    assign full_o            = (cnt_q == FULL_CNT);
    assign issue_ready_o     = !full_o && !flush_i;
    assign issue_trans_id_o  = tail_q;
    assign issue_fire_s      = issue_valid_i && issue_ready_o;
    assign commit_valid_o    = alloc_q[head_q] && done_q[head_q];
    assign commit_fire_s     = commit_valid_o && commit_ack_i;
    assign commit_trans_id_o = head_q;
    assign commit_rd_o       = rd_q[head_q];
    assign commit_result_o   = result_q[head_q];
    assign commit_ex_o       = ex_q[head_q];

    assign rs1_busy_o        = lk_busy_s[0];
    assign rs1_fwd_valid_o   = lk_fwdv_s[0];
    assign rs1_fwd_o         = lk_fwd_s[0];
    assign rs2_busy_o        = lk_busy_s[1];
    assign rs2_fwd_valid_o   = lk_fwdv_s[1];
    assign rs2_fwd_o         = lk_fwd_s[1];

    // Resolve writebacks per entry; ascending scan so the lowest port wins.
    always_comb begin
        wb_hit_s = '0;
        wb_ex_s  = '0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            wb_res_s[e] = '0;
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && !wb_hit_s[e] &&
                    (wb_trans_id_i[p*TRANS_ID_W +: TRANS_ID_W] == TRANS_ID_W'(e))) begin
                    wb_hit_s[e] = 1'b1;
                    wb_ex_s[e]  = wb_ex_i[p];
                    wb_res_s[e] = wb_result_i[p*DATA_W +: DATA_W];
                end else begin
                    // a lower port already claimed this entry, or no match
                end
            end
        end
    end

    // Next-state: flush overrides writeback, commit and issue.
    always_comb begin
        alloc_d  = alloc_q;
        done_d   = done_q;
        ex_d     = ex_q;
        rd_d     = rd_q;
        result_d = result_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            alloc_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            cnt_d   = '0;
        end else begin
            // Only allocated entries accept a writeback; the slot being
            // issued this cycle is not yet allocated and so ignores it.
            for (int e = 0; e < NR_ENTRIES; e++) begin
                if (wb_hit_s[e] && alloc_q[e]) begin
                    done_d[e]   = 1'b1;
                    ex_d[e]     = wb_ex_s[e];
                    result_d[e] = wb_res_s[e];
                end else begin
                    // entry untouched this cycle
                end
            end
            if (commit_fire_s) begin
                alloc_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            if (issue_fire_s) begin
                alloc_d[tail_q]  = 1'b1;
                done_d[tail_q]   = 1'b0;
                ex_d[tail_q]     = 1'b0;
                rd_d[tail_q]     = issue_rd_i;
                result_d[tail_q] = issue_data_i;
                tail_d           = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            case ({issue_fire_s, commit_fire_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Youngest-producer lookup: walk oldest to youngest from head so the
    // last allocated match wins, which honours pointer wrap.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            logic [4:0]            addr;
            logic                  match;
            logic [TRANS_ID_W-1:0] idx;
            logic [TRANS_ID_W-1:0] pos;
            addr  = (r == 0) ? rs1_addr_i : rs2_addr_i;
            match = 1'b0;
            idx   = '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                pos = head_q + TRANS_ID_W'(i);
                if (alloc_q[pos] && (rd_q[pos] == addr)) begin
                    match = 1'b1;
                    idx   = pos;
                end else begin
                    // not a producer of addr
                end
            end
            if (match && (addr != 5'd0)) begin
                lk_busy_s[r] = !done_q[idx];
                lk_fwdv_s[r] = done_q[idx];
                lk_fwd_s[r]  = done_q[idx] ? result_q[idx] : '0;
`ifdef SB_WB_BYPASS_EN
                if (wb_hit_s[idx]) begin
                    lk_busy_s[r] = 1'b0;
                    lk_fwdv_s[r] = 1'b1;
                    lk_fwd_s[r]  = wb_res_s[idx];
                end else begin
                    // no same-cycle writeback for this producer
                end
`endif
            end else begin
                lk_busy_s[r] = 1'b0;
                lk_fwdv_s[r] = 1'b0;
                lk_fwd_s[r]  = '0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            alloc_q <= '0;
            done_q  <= '0;
            ex_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            for (int e = 0; e < NR_ENTRIES; e++) begin
                rd_q[e]     <= 5'd0;
                result_q[e] <= '0;
            end
        end else begin
            alloc_q  <= alloc_d;
            done_q   <= done_d;
            ex_q     <= ex_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

endmodule

// File: doc/sb_ring_buffer.md
Name: sb_ring_buffer

Overview:
Parametrised issue/commit scoreboard ring buffer. It generalises the fixed 4-entry scoreboard in depth, writeback port count and data width. It sits between issue and commit: it allocates transaction IDs in order, collects out-of-order writebacks from the functional units, retires in order, and offers operand forwarding/busy lookup for two source registers.

Parameters:
NR_ENTRIES, 8, scoreboard depth; power of two, >=2; TRANS_ID_W = $clog2(NR_ENTRIES) is a derived localparam
NR_WB_PORTS, 4, number of writeback ports
DATA_W, 64, result/immediate width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
flush_i  in  1  discard all entries
issue_valid_i  in  1  issue request
issue_ready_o  out  1  entry free and no flush
issue_rd_i  in  5  destination register
issue_data_i  in  DATA_W  initial result (immediate)
issue_trans_id_o  out  TRANS_ID_W  ID for the issuing instruction (= tail index)
wb_valid_i  in  NR_WB_PORTS  writeback strobes
wb_trans_id_i  in  NR_WB_PORTS*TRANS_ID_W  writeback IDs, port p at [p*TRANS_ID_W +: TRANS_ID_W]
wb_result_i  in  NR_WB_PORTS*DATA_W  writeback results
wb_ex_i  in  NR_WB_PORTS  writeback carries exception
commit_valid_o  out  1  head entry allocated and written back
commit_ack_i  in  1  commit consumes head
commit_trans_id_o  out  TRANS_ID_W  head index
commit_rd_o  out  5  head rd
commit_result_o  out  DATA_W  head result
commit_ex_o  out  1  head exception flag
rs1_addr_i, rs2_addr_i  in  5  lookup addresses
rs1_busy_o, rs2_busy_o  out  1  youngest producer pending
rs1_fwd_valid_o, rs2_fwd_valid_o  out  1  youngest producer done, result forwardable
rs1_fwd_o, rs2_fwd_o  out  DATA_W  forwarded result
full_o  out  1  count == NR_ENTRIES

Behaviour:
- State: per entry {alloc, done, ex, rd, result}; head/tail pointers (TRANS_ID_W bits, natural wrap); count (TRANS_ID_W+1 bits).
- Reset (rst_ni=0 at posedge): all alloc/done=0, head=tail=count=0. Outputs after reset: issue_ready_o=1, full_o=0, commit_valid_o=0, busy/fwd_valid=0. Reset mid-operation drops all entries.
- Issue: fires when issue_valid_i && issue_ready_o. issue_ready_o = !full_o && !flush_i. On the next edge: entry[tail] gets alloc=1, done=0, ex=0, rd, result=issue_data_i; tail+1; count+1. issue_trans_id_o = tail, combinational.
- Full: issue stays blocked while full, even if commit_ack_i fires in the same cycle. No full-bypass.
- Writeback: for each port with wb_valid_i, entry[id] gets done=1, result, ex. Ignored if entry not alloc, including an entry issued this same cycle. Two ports naming the same ID in one cycle: lowest port index wins.
- Commit: commit_valid_o = alloc[head] && done[head], from registered state only; latency is >=1 cycle after writeback. commit_ack_i while commit_valid_o is high: alloc[head]=0, head+1, count-1. Ack without valid is ignored.
- Issue and commit in the same cycle: count unchanged, both pointers advance.
- Flush: highest priority. At the next edge all alloc/done are cleared, head=tail=count=0, and same-cycle issue/writeback/commit are ignored.
- Lookup per rsN, combinational over registered state:
  - rs addr 0: busy=0, fwd_valid=0.
  - Otherwise select the youngest alloc entry (closest to tail) with rd == addr.
  - busy = match && !done; fwd_valid = match && done; fwd = that entry's result, else 0.
- Pointer wrap: modulo NR_ENTRIES. The youngest-match search honours wrap order.

Optional Feature:
SB_WB_BYPASS_EN
- Defined: the lookup also considers same-cycle writebacks. If the youngest matching entry is being written back this cycle, busy=0, fwd_valid=1, and fwd = wb_result_i of the winning port. commit_valid_o is unchanged, still registered.
- Undefined: lookup uses registered state only, as above.

Test Plan:
- Reset, then issue 8 instructions (rd=1..8) with no writeback -> IDs 0..7, full_o=1 after the 8th, issue_ready_o=0, commit_valid_o=0.
- Writeback ID 2 (0xAA) then ID 0 (0x55) -> commit_valid_o rises 1 cycle after the ID-0 writeback, commit_result_o=0x55. Ack -> head=1, commit_valid_o=0 until ID 1 is written back.
- Ports 0 and 3 write ID 5 in the same cycle with 0x11/0x33 -> stored result 0x11.
- Issue rd=7 twice (IDs 0,1), writeback ID 0 with 0x9 -> rs1_addr_i=7 gives busy=1, fwd_valid=0. Writeback ID 1 with 0xC -> fwd_valid=1, fwd=0xC. rs2_addr_i=0 -> both flags 0.
- Fill to wrap (tail passes 7->0) with interleaved commit; issue+ack in the same cycle -> count constant. While full with ack active, issue_ready_o stays 0.
- Assert flush_i together with issue_valid_i and wb_valid_i -> next cycle count=0, head=tail=0, commit_valid_o=0, issue_trans_id_o=0.
